// File: rtl/cpu_types_pkg.sv
// Shared types for the pipeline controller: register/word widths, the
// controller state encoding and the packed bundle of latch controls.
package cpu_types_pkg;

   typedef logic [31:0] word_t;
   typedef logic [4:0]  regbits_t;

   typedef enum logic [2:0] {
      RUN      = 3'd0,
      MEMWAIT  = 3'd1,
      LDUSE    = 3'd2,
      REDIRECT = 3'd3,
      HALTED   = 3'd4
   } pipe_state_t;

   // One bit per latch control, in the order the outputs are listed.
   typedef struct packed {
      logic pc_wen;
      logic ifid_wen;
      logic idex_wen;
      logic exmem_wen;
      logic memwb_wen;
      logic ifid_flush;
      logic idex_flush;
      logic exmem_flush;
      logic memwb_flush;
      logic halt;
   } pipe_ctrl_t;

   localparam word_t WORD_MAX = '1;

   // Increment that sticks at all-ones instead of wrapping.
   function automatic word_t sat_inc(input word_t value);
      return (value == WORD_MAX) ? value : value + 32'd1;
   endfunction

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Hazard/status inputs and latch-control outputs of the pipeline controller.
// master: datapath side, slave: controller side.
// The performance counters exist only when PIPE_PERF_EN is defined.
interface pipeline_ctrl_if;
   import cpu_types_pkg::*;

   logic     ihit;
   logic     dhit;
   logic     dmem_req;
   logic     memread_ex;
   regbits_t rt_ex;
   regbits_t rs_id;
   regbits_t rt_id;
   logic     redirect_mem;
   logic     halt_wb;

   logic     pc_wen;
   logic     ifid_wen;
   logic     idex_wen;
   logic     exmem_wen;
   logic     memwb_wen;
   logic     ifid_flush;
   logic     idex_flush;
   logic     exmem_flush;
   logic     memwb_flush;
   logic     halt;

`ifdef PIPE_PERF_EN
   word_t    stall_cnt;
   word_t    flush_cnt;
`endif

   modport master (
      output ihit, dhit, dmem_req, memread_ex, rt_ex, rs_id, rt_id,
             redirect_mem, halt_wb,
      input  pc_wen, ifid_wen, idex_wen, exmem_wen, memwb_wen,
             ifid_flush, idex_flush, exmem_flush, memwb_flush, halt
`ifdef PIPE_PERF_EN
      , input stall_cnt, flush_cnt
`endif
   );

   modport slave (
      input  ihit, dhit, dmem_req, memread_ex, rt_ex, rs_id, rt_id,
             redirect_mem, halt_wb,
      output pc_wen, ifid_wen, idex_wen, exmem_wen, memwb_wen,
             ifid_flush, idex_flush, exmem_flush, memwb_flush, halt
`ifdef PIPE_PERF_EN
      , output stall_cnt, flush_cnt
`endif
   );

endinterface

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Load-use detector: a load in EX whose destination feeds the instruction in ID.
// Register 0 is hard-wired, so a load targeting it never creates a hazard.
module hazard_detect
   import cpu_types_pkg::*;
(
   input  logic     memread_ex,
   input  regbits_t rt_ex,
   input  regbits_t rs_id,
   input  regbits_t rt_id,
   output logic     load_use
);

   // Pure combinational compare against both ID source operands.
   always_comb begin
      load_use = memread_ex && (rt_ex != '0) && ((rt_ex == rs_id) || (rt_ex == rt_id));
   end

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline hazard/stall controller: latch write enables and bubble inserts.
// Optional build macro PIPE_PERF_EN adds saturating stall/flush counters.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// RUN      | normal flow, all hazards evaluated
// MEMWAIT  | previous cycle was a memory stall; leaves on first clean cycle
// LDUSE    | one bubble inserted for a load-use; no re-detection this cycle
// REDIRECT | redirect taken last cycle; flush the stale fetch in IF/ID once
// HALTED   | halt retired; everything frozen until reset
module pipeline_ctrl
   import cpu_types_pkg::*;
(
   input  logic            CLK,
   input  logic            nRST,
   pipeline_ctrl_if.slave  pif
);

   pipe_state_t state;
   pipe_state_t state_nxt;
   pipe_ctrl_t  ctrl;
   pipe_ctrl_t  ctrl_out;
   logic        load_use;
   logic        mem_stall;

   hazard_detect u_hazard_detect (
      .memread_ex (pif.memread_ex),
      .rt_ex      (pif.rt_ex),
      .rs_id      (pif.rs_id),
      .rt_id      (pif.rt_id),
      .load_use   (load_use)
   );

   assign mem_stall = (pif.dmem_req & ~pif.dhit) | ~pif.ihit;

   // Priority decode: halted, halt retiring, memory stall, redirect, load-use, run.
   always_comb begin
      ctrl      = '0;
      state_nxt = state;
      if (state == HALTED) begin
         ctrl.halt = 1'b1;
      end else if (pif.halt_wb) begin
         state_nxt = HALTED;
      end else if (mem_stall) begin
         // Front of the pipe freezes (a pending redirect stays in MEM), a bubble drains into WB.
         ctrl.memwb_wen   = 1'b1;
         ctrl.memwb_flush = 1'b1;
         state_nxt        = MEMWAIT;
      end else if (pif.redirect_mem) begin
         ctrl.pc_wen      = 1'b1;
         ctrl.ifid_wen    = 1'b1;
         ctrl.idex_wen    = 1'b1;
         ctrl.exmem_wen   = 1'b1;
         ctrl.memwb_wen   = 1'b1;
         ctrl.ifid_flush  = 1'b1;
         ctrl.idex_flush  = 1'b1;
         ctrl.exmem_flush = 1'b1;
         state_nxt        = REDIRECT;
      end else if (state == REDIRECT) begin
         ctrl.pc_wen     = 1'b1;
         ctrl.ifid_wen   = 1'b1;
         ctrl.idex_wen   = 1'b1;
         ctrl.exmem_wen  = 1'b1;
         ctrl.memwb_wen  = 1'b1;
         ctrl.ifid_flush = 1'b1;
         state_nxt       = RUN;
      end else if (load_use && (state != LDUSE)) begin
         ctrl.idex_wen   = 1'b1;
         ctrl.exmem_wen  = 1'b1;
         ctrl.memwb_wen  = 1'b1;
         ctrl.idex_flush = 1'b1;
         state_nxt       = LDUSE;
      end else begin
         ctrl.pc_wen    = 1'b1;
         ctrl.ifid_wen  = 1'b1;
         ctrl.idex_wen  = 1'b1;
         ctrl.exmem_wen = 1'b1;
         ctrl.memwb_wen = 1'b1;
         state_nxt      = RUN;
      end
   end

   // State register; reset drops any in-flight stall/redirect sequence.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) state <= RUN;
      else       state <= state_nxt;
   end

   // Outputs are combinational, so they are masked for as long as reset is held.
   always_comb begin
      ctrl_out = nRST ? ctrl : '0;
   end

   assign pif.pc_wen      = ctrl_out.pc_wen;
   assign pif.ifid_wen    = ctrl_out.ifid_wen;
   assign pif.idex_wen    = ctrl_out.idex_wen;
   assign pif.exmem_wen   = ctrl_out.exmem_wen;
   assign pif.memwb_wen   = ctrl_out.memwb_wen;
   assign pif.ifid_flush  = ctrl_out.ifid_flush;
   assign pif.idex_flush  = ctrl_out.idex_flush;
   assign pif.exmem_flush = ctrl_out.exmem_flush;
   assign pif.memwb_flush = ctrl_out.memwb_flush;
   assign pif.halt        = ctrl_out.halt;

`ifdef PIPE_PERF_EN
   logic  stall_evt;
   logic  redir_evt;
   word_t stall_cnt;
   word_t flush_cnt;

   // Each event has a unique control signature: memwb_flush only on a memory
   // stall, idex_flush without ifid_flush only on load-use, exmem_flush only on
   // a redirect. None of them fire in HALTED, which freezes both counters.
   assign stall_evt = ctrl.memwb_flush | (ctrl.idex_flush & ~ctrl.ifid_flush);
   assign redir_evt = ctrl.exmem_flush;

   // Saturating event counters.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (stall_evt) stall_cnt <= sat_inc(stall_cnt);
         if (redir_evt) flush_cnt <= sat_inc(flush_cnt);
      end
   end

   assign pif.stall_cnt = stall_cnt;
   assign pif.flush_cnt = flush_cnt;
`endif

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 SHALL have port CLK, input, 1, pipeline clock; all state updates on the rising edge.
REQ-002 SHALL have port nRST, input, 1, reset; asynchronous, active-low.
REQ-003 SHALL have port ihit, input, 1, the instruction fetch completed this cycle.
REQ-004 SHALL have port dhit, input, 1, the data access in MEM completed this cycle.
REQ-005 SHALL have port dmem_req, input, 1, the instruction in MEM issues a data read or write.
REQ-006 SHALL have ports memread_ex (input, 1) and rt_ex (input, regbits_t), which identify a load in EX and its destination.
REQ-007 SHALL have ports rs_id and rt_id, input, regbits_t, the source registers of the instruction in ID.
REQ-008 SHALL have port redirect_mem, input, 1, a taken branch or jump resolved in MEM.
REQ-009 SHALL have port halt_wb, input, 1, a halt instruction is in WB.
REQ-010 SHALL have ports pc_wen, ifid_wen, idex_wen, exmem_wen, memwb_wen, output, 1 each, latch write enables.
REQ-011 SHALL have ports ifid_flush, idex_flush, exmem_flush, memwb_flush, output, 1 each, latch clears that insert a bubble.
REQ-012 SHALL have port halt, output, 1, the pipeline is halted.

Function
REQ-013 SHALL hold a registered state in {RUN, MEMWAIT, LDUSE, REDIRECT, HALTED}; outputs are combinational from the state and inputs.
REQ-014 SHALL evaluate the following per cycle in strict priority order: HALTED > halt_wb > memory stall > redirect > load-use > run.
REQ-015 SHALL, in HALTED, drive all wen and flush signals to 0 and halt to 1, and remain there until reset.
REQ-016 SHALL, on halt_wb=1, drive all wen=0 and go to HALTED at the next edge.
REQ-017 SHALL define a memory stall as (dmem_req & !dhit) | !ihit; during a stall, pc, ifid, idex and exmem wen=0, memwb_wen=1 with memwb_flush=1, and the next state is MEMWAIT; the FSM leaves MEMWAIT on the first non-stall cycle.
REQ-018 SHALL, on redirect_mem=1 with no stall, set all wen=1 and ifid_flush=idex_flush=exmem_flush=1, then enter REDIRECT.
REQ-019 SHALL, in REDIRECT, additionally assert ifid_flush for exactly one cycle, which discards the stale fetch, then return to RUN.
REQ-020 SHALL define load-use as memread_ex & (rt_ex!=0) & (rt_ex==rs_id | rt_ex==rt_id); on load-use, pc_wen=ifid_wen=0, idex_flush=1, the remaining wen=1, and the next state is LDUSE.
REQ-021 SHALL NOT re-detect load-use while in LDUSE; LDUSE returns to RUN after one cycle.
REQ-022 SHALL, in RUN with no event, set every wen=1 and every flush=0.
REQ-023 SHALL, when a stall and a redirect coincide, honour the stall, hold redirect_mem pending in the frozen MEM latch, and act on the redirect on the first non-stall cycle.

Reset
REQ-024 SHALL, while nRST=0, force state=RUN, every wen=0, every flush=0 and halt=0; normal operation resumes on the first edge after release.
REQ-025 SHALL abandon any in-progress MEMWAIT, LDUSE or REDIRECT immediately on reset.

Configuration
REQ-026 SHALL, with PIPE_PERF_EN defined, add outputs stall_cnt and flush_cnt (word_t each), cleared on reset; stall_cnt increments on every memory-stall or load-use cycle, flush_cnt increments on every redirect event, both saturate at all-ones, and both freeze in HALTED.
REQ-027 SHALL, without PIPE_PERF_EN, have neither the counters nor their ports.

Structure
REQ-028 SHALL place the state enum pipe_state_t in cpu_types_pkg and use word_t and regbits_t from that package.
REQ-029 SHALL implement hazard_detect as a combinational sub-module that produces the load-use term.

Verification
REQ-030 SHALL cover: dmem_req=1, dhit=0 for 3 cycles -> pc/ifid/idex/exmem wen=0 for 3 cycles, 3 bubbles enter WB, RUN on the 4th cycle.
REQ-031 SHALL cover: memread_ex=1, rt_ex=5, rs_id=5 -> one cycle with pc_wen=ifid_wen=0 and idex_flush=1, with no repeat stall in the following cycle.
REQ-032 SHALL cover: rt_ex=0 with matching rs_id=0 -> no stall.
REQ-033 SHALL cover: redirect_mem=1 -> ifid/idex/exmem flush that cycle, ifid_flush only in the next cycle, then RUN.
REQ-034 SHALL cover: redirect_mem=1 together with ihit=0 for 2 cycles -> freeze for 2 cycles, then the redirect flush.
REQ-035 SHALL cover: halt_wb=1, then nRST pulsed low mid-HALTED -> halt=1 until reset, RUN after release, and with PIPE_PERF_EN both counters read 0.
